stopwatch_ctrl: RTL and testbench

Control sequencer between the debounced button levels and the stopwatch counter/display datapath. It edge-detects three debounced buttons and runs a start/stop/lap/clear state machine. It also generates the centisecond count-enable strobe from the system clock and issues a clear pulse on a short press (when paused) or a long press (when running). It sits downstream of the three debouncers and drives the BCD counter chain and the display freeze mux.

---
 rtl/stopwatch_ctrl_if.sv | 33 +++
 rtl/stopwatch_ctrl.sv | 143 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
//   Groups the debounced button levels and the control outputs that pass
//   between the button front end, the sequencer and the counter/display datapath.
//   Signals:
//     btn_start_stop, btn_lap, btn_reset : debounced button levels, 1 = pressed
//     count_en : one-cycle strobe, advance the counter by one tick
//     clear    : one-cycle strobe, zero the counter and lap register
//     lap_hold : level, freeze the display at its current value
//     running  : level, state is RUN or LAP
//     state    : IDLE=0, RUN=1, PAUSE=2, LAP=3
//   Modports:
//     master : drives the buttons and observes the control outputs
//     slave  : the sequencer, which takes the buttons and drives the outputs
interface stopwatch_ctrl_if;
  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_reset;
  logic       count_en;
  logic       clear;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  modport master (
    output btn_start_stop, btn_lap, btn_reset,
    input  count_en, clear, lap_hold, running, state
  );

  modport slave (
    input  btn_start_stop, btn_lap, btn_reset,
    output count_en, clear, lap_hold, running, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control sequencer between the button debouncers and the stopwatch
//   counter/display datapath. It edge-detects the three buttons, runs the
//   start/stop/lap/clear state machine, divides the system clock down to the
//   count-enable tick, and detects a long reset press while running.
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-high reset
//     bus : stopwatch_ctrl_if.slave (buttons in; count_en, clear, lap_hold,
//           running and state out, all registered)
module stopwatch_ctrl #(
  parameter int CLK_FREQ_HZ      = 100_000_000,
  parameter int TICK_HZ          = 100,
  parameter int LONG_PRESS_TICKS = 100
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int HW  = $clog2(LONG_PRESS_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          prev_ss, prev_lap, prev_rs;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          count_en_q, count_en_d;
  logic          clear_q, clear_d;
  logic          lap_hold_q, running_q;

  logic press_ss, press_lap, press_rs;
  logic tick, active, long_fire;

  // Edge memories reset to 1, so a button held through reset needs a
  // release and a fresh press before it does anything.
  assign press_ss  = bus.btn_start_stop & ~prev_ss;
  assign press_lap = bus.btn_lap        & ~prev_lap;
  assign press_rs  = bus.btn_reset      & ~prev_rs;

  assign tick   = (presc_q == PRESC_MAX);
  assign active = (state_q == RUN) || (state_q == LAP);

  // The long press fires on the tick that would bring the hold count up to
  // LONG_PRESS_TICKS, so the clear lands on that tick rather than one later.
  assign long_fire = active && bus.btn_reset && tick && (hold_q >= HOLD_LAST);

  // Next state, strobes and counters. A long press outranks every button,
  // then the reset press, then start/stop, then lap.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    hold_d  = hold_q;
    presc_d = tick ? '0 : presc_q + PW'(1);

    if (long_fire) begin
      clear_d = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_rs)      clear_d = 1'b1;
          else if (press_ss) state_d = RUN;
        end
        RUN: begin
          if (press_ss)       state_d = PAUSE;
          else if (press_lap) state_d = LAP;
        end
        LAP: begin
          if (press_ss)       state_d = PAUSE;
          else if (press_lap) state_d = RUN;
        end
        PAUSE: begin
          if (press_rs) begin
            clear_d = 1'b1;
            state_d = IDLE;
          end else if (press_ss) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (!active || !bus.btn_reset || long_fire) begin
      hold_d = '0;
    end else if (tick && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
    end

    // Clearing restarts the tick phase so the first count after a clear is a
    // full tick period away.
    if (clear_d) presc_d = '0;

    count_en_d = tick && ((state_d == RUN) || (state_d == LAP)) && !clear_d;
  end

  // All state and outputs register here; reset drops every strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_ss    <= 1'b1;
      prev_lap   <= 1'b1;
      prev_rs    <= 1'b1;
      presc_q    <= '0;
      hold_q     <= '0;
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
      lap_hold_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_ss    <= bus.btn_start_stop;
      prev_lap   <= bus.btn_lap;
      prev_rs    <= bus.btn_reset;
      presc_q    <= presc_d;
      hold_q     <= hold_d;
      count_en_q <= count_en_d;
      clear_q    <= clear_d;
      lap_hold_q <= (state_d == LAP);
      running_q  <= (state_d == RUN) || (state_d == LAP);
    end
  end

  assign bus.state    = state_q;
  assign bus.count_en = count_en_q;
  assign bus.clear    = clear_q;
  assign bus.lap_hold = lap_hold_q;
  assign bus.running  = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with DIV=10 and a three-tick long
//   press. A directed vector table opens the run, hand-written sequences cover
//   the multi-cycle corners, and a randomized run is compared every cycle
//   against a behavioural model of the sequencer.
module tb_stopwatch_ctrl;

  localparam int CLK_FREQ_HZ      = 100;
  localparam int TICK_HZ          = 10;
  localparam int LONG_PRESS_TICKS = 3;
  localparam int DIV              = CLK_FREQ_HZ / TICK_HZ;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_FREQ_HZ      (CLK_FREQ_HZ),
    .TICK_HZ          (TICK_HZ),
    .LONG_PRESS_TICKS (LONG_PRESS_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Behavioural model: state as an integer, tick phase counted modulo DIV.
  int m_state;
  int m_phase;
  int m_hold;
  bit m_prev_ss, m_prev_lap, m_prev_rs;
  bit m_count_en, m_clear, m_lap_hold, m_running;

  typedef struct {
    bit         ss;
    bit         lap;
    bit         rs;
    logic [1:0] st;
    bit         ce;
    bit         clr;
    bit         lh;
    bit         run;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [7:0] dutOut();
    return {2'b00, sw_if.count_en, sw_if.clear, sw_if.lap_hold, sw_if.running, sw_if.state};
  endfunction

  function automatic logic [7:0] modelOut();
    logic [1:0] st;
    st = 2'(m_state);
    return {2'b00, m_count_en, m_clear, m_lap_hold, m_running, st};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    m_state    = 0;
    m_phase    = 0;
    m_hold     = 0;
    m_prev_ss  = 1'b1;
    m_prev_lap = 1'b1;
    m_prev_rs  = 1'b1;
    m_count_en = 1'b0;
    m_clear    = 1'b0;
    m_lap_hold = 1'b0;
    m_running  = 1'b0;
  endtask

  task automatic modelStep(input bit ss, input bit lap, input bit rs);
    bit p_ss, p_lap, p_rs, tick, active, long_press;
    int nxt;
    p_ss  = ss  && !m_prev_ss;
    p_lap = lap && !m_prev_lap;
    p_rs  = rs  && !m_prev_rs;
    m_prev_ss  = ss;
    m_prev_lap = lap;
    m_prev_rs  = rs;
    tick   = (m_phase == DIV - 1);
    active = (m_state == 1) || (m_state == 3);
    long_press = active && rs && tick && (m_hold + 1 >= LONG_PRESS_TICKS);
    m_clear = 1'b0;
    nxt = m_state;
    if (long_press) begin
      m_clear = 1'b1;
      nxt = 0;
    end else if (m_state == 0) begin
      if (p_rs) m_clear = 1'b1;
      else if (p_ss) nxt = 1;
    end else if (m_state == 1) begin
      if (p_ss) nxt = 2;
      else if (p_lap) nxt = 3;
    end else if (m_state == 3) begin
      if (p_ss) nxt = 2;
      else if (p_lap) nxt = 1;
    end else begin
      if (p_rs) begin
        m_clear = 1'b1;
        nxt = 0;
      end else if (p_ss) nxt = 1;
    end
    if (!active || !rs || long_press) m_hold = 0;
    else if (tick && m_hold < LONG_PRESS_TICKS) m_hold = m_hold + 1;
    m_phase    = m_clear ? 0 : (m_phase + 1) % DIV;
    m_count_en = tick && (nxt == 1 || nxt == 3) && !m_clear;
    m_state    = nxt;
    m_running  = (nxt == 1) || (nxt == 3);
    m_lap_hold = (nxt == 3);
  endtask

  // Drive one cycle of button levels, advance the model on the edge, and
  // compare the whole output bundle on the following falling edge.
  task automatic applyStimulus(input bit ss, input bit lap, input bit rs);
    sw_if.btn_start_stop = ss;
    sw_if.btn_lap        = lap;
    sw_if.btn_reset      = rs;
    @(posedge clk);
    modelStep(ss, lap, rs);
    @(negedge clk);
    checkOutput("model", dutOut(), modelOut());
  endtask

  // Called on a falling edge: raise reset mid-cycle, confirm the outputs drop
  // before any clock edge, then release it on a later falling edge.
  task automatic doReset(input int cycles);
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput("async_reset", dutOut(), 8'h00);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int clears;
    bit r_ss, r_lap, r_rs;

    vecs[0]  = '{0,0,0, 2'd0, 0,0,0,0};
    vecs[1]  = '{1,0,0, 2'd1, 0,0,0,1};
    vecs[2]  = '{1,0,0, 2'd1, 0,0,0,1};
    vecs[3]  = '{0,0,0, 2'd1, 0,0,0,1};
    vecs[4]  = '{0,1,0, 2'd3, 0,0,1,1};
    vecs[5]  = '{0,0,0, 2'd3, 0,0,1,1};
    vecs[6]  = '{0,1,0, 2'd1, 0,0,0,1};
    vecs[7]  = '{0,0,0, 2'd1, 0,0,0,1};
    vecs[8]  = '{0,0,0, 2'd1, 0,0,0,1};
    vecs[9]  = '{0,0,0, 2'd1, 1,0,0,1};
    vecs[10] = '{0,0,0, 2'd1, 0,0,0,1};
    vecs[11] = '{0,0,1, 2'd1, 0,0,0,1};
    vecs[12] = '{0,0,0, 2'd1, 0,0,0,1};
    vecs[13] = '{1,0,0, 2'd2, 0,0,0,0};
    vecs[14] = '{0,0,0, 2'd2, 0,0,0,0};
    vecs[15] = '{0,0,1, 2'd0, 0,1,0,0};
    vecs[16] = '{0,0,0, 2'd0, 0,0,0,0};
    vecs[17] = '{0,1,0, 2'd0, 0,0,0,0};
    vecs[18] = '{0,0,0, 2'd0, 0,0,0,0};

    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_lap        = 1'b0;
    sw_if.btn_reset      = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_state", dutOut(), 8'h00);
    rst = 1'b0;

    // Directed table straight out of reset
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].ss, vecs[i].lap, vecs[i].rs);
      checkOutput($sformatf("vec%0d", i), dutOut(),
                  {2'b00, vecs[i].ce, vecs[i].clr, vecs[i].lh, vecs[i].run, vecs[i].st});
    end

    // Start held two cycles, then exactly five strobes in fifty cycles
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("start_state", {6'd0, sw_if.state}, 8'd1);
    checkOutput("start_running", {7'd0, sw_if.running}, 8'd1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 0, 0);
      if (sw_if.count_en) n++;
    end
    checkOutput("strobes_50", 8'(n), 8'd5);

    // Lap freezes the display while counting continues
    applyStimulus(0, 1, 0);
    checkOutput("lap_state", {6'd0, sw_if.state}, 8'd3);
    checkOutput("lap_hold_on", {7'd0, sw_if.lap_hold}, 8'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0);
      if (sw_if.count_en) n++;
    end
    checkOutput("lap_strobes_20", 8'(n), 8'd2);
    applyStimulus(0, 1, 0);
    checkOutput("unlap_state", {6'd0, sw_if.state, sw_if.lap_hold}, {6'd0, 2'd1, 1'b0});
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("stop_state", {6'd0, sw_if.state}, 8'd2);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 0, 0);
      if (sw_if.count_en) n++;
    end
    checkOutput("pause_strobes", 8'(n), 8'd0);

    // Clear from pause restarts the tick phase
    applyStimulus(0, 0, 1);
    checkOutput("pause_clear", {6'd0, sw_if.clear, sw_if.state}, {6'd0, 1'b1, 2'd0});
    applyStimulus(1, 0, 0);
    checkOutput("clear_width", {7'd0, sw_if.clear}, 8'd0);
    n = 1;
    while (sw_if.count_en !== 1'b1 && n < 30) begin
      applyStimulus(0, 0, 0);
      n++;
    end
    checkOutput("first_tick_after_clear", 8'(n), 8'd10);

    // Long press while running clears once, then a continued hold does nothing
    clears = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 1);
      if (sw_if.clear) begin
        clears++;
        checkOutput("long_clear_no_count", {7'd0, sw_if.count_en}, 8'd0);
      end
    end
    checkOutput("long_clears", 8'(clears), 8'd1);
    checkOutput("long_state", {6'd0, sw_if.state}, 8'd0);
    clears = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 0, 1);
      if (sw_if.clear) clears++;
    end
    checkOutput("long_hold_extra_clears", 8'(clears), 8'd0);
    applyStimulus(0, 0, 0);

    // Coincident start/stop and reset in pause: reset wins
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("pre_coincide_state", {6'd0, sw_if.state}, 8'd2);
    applyStimulus(1, 0, 1);
    checkOutput("coincide_clear", {6'd0, sw_if.clear, sw_if.state}, {6'd0, 1'b1, 2'd0});
    applyStimulus(0, 0, 0);

    // Stop press on a tick gives no strobe; start press on a tick does
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < DIV && m_phase != DIV - 1; k++) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("stop_on_tick", {6'd0, sw_if.count_en, sw_if.state}, {6'd0, 1'b0, 2'd2});
    applyStimulus(0, 0, 0);
    for (int k = 0; k < DIV && m_phase != DIV - 1; k++) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("start_on_tick", {6'd0, sw_if.count_en, sw_if.state}, {6'd0, 1'b1, 2'd1});

    // Start held across reset release has no effect
    sw_if.btn_start_stop = 1'b1;
    doReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
    checkOutput("held_through_reset", {6'd0, sw_if.state}, 8'd0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < DIV && m_phase != 4; k++) applyStimulus(0, 0, 0);
    checkOutput("mid_run_state", {6'd0, sw_if.state}, 8'd1);

    // Reset mid-run, then the first strobe ten cycles after release
    sw_if.btn_start_stop = 1'b0;
    doReset(3);
    applyStimulus(0, 0, 0);
    n = 1;
    applyStimulus(1, 0, 0);
    n = 2;
    while (sw_if.count_en !== 1'b1 && n < 30) begin
      applyStimulus(0, 0, 0);
      n++;
    end
    checkOutput("first_tick_after_reset", 8'(n), 8'd10);

    // Randomized button activity against the model
    r_ss = 1'b0;
    r_lap = 1'b0;
    r_rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  r_ss  = !r_ss;
      if ($urandom_range(0, 5) == 0)  r_lap = !r_lap;
      if ($urandom_range(0, 39) == 0) r_rs  = !r_rs;
      if ($urandom_range(0, 299) == 0) doReset(2);
      applyStimulus(r_ss, r_lap, r_rs);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
